// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encodings, IF/ID flush NOP word, default register address width.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    // sll $0,$0,0 : word loaded into IF/ID when it is flushed
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: load in EX writes a register read by ID.
// Ports: mem_read/ex_rt (EX load), id_rs/id_rt (ID sources) -> hazard.
module pipeline_hazard_ctrl_load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  hazard
);

    // $zero is never really written, so it cannot create a dependency
    assign hazard = mem_read
                  && (ex_rt != '0)
                  && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers.
// Inputs: load-use operands, redirect_i, dmem_req_i/dmem_ack_i.
// Outputs: per-stage write/flush/bubble controls, sticky timeout_o.
// Option HAZARD_STALL_CNT_EN adds stall_cnt_o and flush_cnt_o counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  IDEX_memRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_rt_i,
    input  logic [REG_ADDR_W-1:0] IFID_rs_i,
    input  logic [REG_ADDR_W-1:0] IFID_rt_i,
    input  logic                  redirect_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ack_i,
    output logic                  pc_write_o,
    output logic                  IFID_write_o,
    output logic                  IFID_flush_o,
    output logic                  IDEX_bubble_o,
    output logic                  stage_write_o,
    output logic                  MEMWB_bubble_o,
    output logic                  timeout_o
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    state_t            state_q;
    state_t            state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic              timeout_q;
    logic              timeout_d;
    logic              lu_hold_q;
    logic              lu_stall;
    logic              hazard;

    pipeline_hazard_ctrl_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .mem_read (IDEX_memRead_i),
        .ex_rt    (IDEX_rt_i),
        .id_rs    (IFID_rs_i),
        .id_rt    (IFID_rt_i),
        .hazard   (hazard)
    );

    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        timeout_d      = timeout_q;
        lu_stall       = 1'b0;
        pc_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        stage_write_o  = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        MEMWB_bubble_o = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    pc_write_o     = 1'b0;
                    IFID_write_o   = 1'b0;
                    stage_write_o  = 1'b0;
                    MEMWB_bubble_o = 1'b1;
                    wcnt_d         = '0;
                    state_d        = ST_MEM_WAIT;
                end else if (hazard && !lu_hold_q) begin
                    // load moves on to MEM, ID holds, EX gets a bubble
                    pc_write_o    = 1'b0;
                    IFID_write_o  = 1'b0;
                    IDEX_bubble_o = 1'b1;
                    lu_stall      = 1'b1;
                end else if (redirect_i) begin
                    IFID_flush_o = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    wcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    pc_write_o     = 1'b0;
                    IFID_write_o   = 1'b0;
                    stage_write_o  = 1'b0;
                    MEMWB_bubble_o = 1'b1;
                    if (wcnt_q != WCNT_MAX) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                    if (wcnt_d == WCNT_MAX) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (!rst_i) begin
            pc_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            stage_write_o  = 1'b0;
            IFID_flush_o   = 1'b1;
            IDEX_bubble_o  = 1'b1;
            MEMWB_bubble_o = 1'b1;
        end
    end

    assign timeout_o = timeout_q;

    // lu_hold_q: the cycle after a load-use stall EX holds the bubble,
    // so the same hazard must not stall a second time
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
            lu_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            lu_hold_q <= lu_stall;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!pc_write_o) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (IFID_flush_o) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios
// followed by random traffic, all checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int MT = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          IDEX_memRead_i = 1'b0;
    logic [RW-1:0] IDEX_rt_i = '0;
    logic [RW-1:0] IFID_rs_i = '0;
    logic [RW-1:0] IFID_rt_i = '0;
    logic          redirect_i = 1'b0;
    logic          dmem_req_i = 1'b0;
    logic          dmem_ack_i = 1'b0;
    logic          pc_write_o;
    logic          IFID_write_o;
    logic          IFID_flush_o;
    logic          IDEX_bubble_o;
    logic          stage_write_o;
    logic          MEMWB_bubble_o;
    logic          timeout_o;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0]   stall_cnt_o;
    logic [31:0]   flush_cnt_o;
`endif

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (RW),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_memRead_i (IDEX_memRead_i),
        .IDEX_rt_i      (IDEX_rt_i),
        .IFID_rs_i      (IFID_rs_i),
        .IFID_rt_i      (IFID_rt_i),
        .redirect_i     (redirect_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ack_i     (dmem_ack_i),
        .pc_write_o     (pc_write_o),
        .IFID_write_o   (IFID_write_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .stage_write_o  (stage_write_o),
        .MEMWB_bubble_o (MEMWB_bubble_o),
        .timeout_o      (timeout_o)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: memory wait in progress, cycles waited, timeout flag,
    // whether last cycle was a load-use stall, event counts
    bit          m_wait;
    int          m_waited;
    bit          m_to;
    bit          m_prev;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] obs();
        return {pc_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
                stage_write_o, MEMWB_bubble_o, timeout_o};
    endfunction

    task automatic model_clear();
        m_wait    = 0;
        m_waited  = 0;
        m_to      = 0;
        m_prev    = 0;
        m_stalls  = '0;
        m_flushes = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        IDEX_memRead_i = 0;
        IDEX_rt_i      = '0;
        IFID_rs_i      = '0;
        IFID_rt_i      = '0;
        redirect_i     = 0;
        dmem_req_i     = 0;
        dmem_ack_i     = 0;
        rst_i          = 0;
        #1;
        check("rst_ctl", 32'(obs()), 32'(7'b0011010));
        model_clear();
`ifdef HAZARD_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_flush_cnt", flush_cnt_o, 32'd0);
`endif
        repeat (2) @(negedge clk_i);
        rst_i = 1;
    endtask

    // one clock cycle: drive inputs, compare outputs, advance the model
    task automatic step(input bit mr, input logic [RW-1:0] ert,
                        input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input bit rd, input bit rq, input bit ak);
        bit         hz;
        bit         frz;
        logic [6:0] e;
        @(negedge clk_i);
        IDEX_memRead_i = mr;
        IDEX_rt_i      = ert;
        IFID_rs_i      = rs;
        IFID_rt_i      = rt;
        redirect_i     = rd;
        dmem_req_i     = rq;
        dmem_ack_i     = ak;
        #1;
        hz  = mr && (ert != 0) && (ert == rs || ert == rt) && !m_prev;
        frz = m_wait ? !ak : (rq && !ak);
        if (frz)
            e = {6'b000001, m_to};
        else if (!m_wait && hz)
            e = {6'b000110, m_to};
        else if (!m_wait && rd)
            e = {6'b111010, m_to};
        else
            e = {6'b110010, m_to};
        check("ctl", 32'(obs()), 32'(e));
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt", stall_cnt_o, m_stalls);
        check("flush_cnt", flush_cnt_o, m_flushes);
`endif
        if (!e[6]) m_stalls++;
        if (e[4]) m_flushes++;
        m_prev = !frz && !m_wait && hz;
        if (m_wait) begin
            if (ak) begin
                m_wait   = 0;
                m_waited = 0;
            end else begin
                if (m_waited < MT) m_waited++;
                if (m_waited == MT) m_to = 1;
            end
        end else if (frz) begin
            m_wait   = 1;
            m_waited = 0;
        end
    endtask

    initial begin
        model_clear();
        do_reset();

        // load-use on rs: one stall, then advance with inputs held
        step(1, 5'd2, 5'd2, 5'd7, 0, 0, 0);
        check("s1_pc_stall", 32'(pc_write_o), 32'd0);
        check("s1_bubble", 32'(IDEX_bubble_o), 32'd1);
        step(1, 5'd2, 5'd2, 5'd7, 0, 0, 0);
        check("s1_pc_next", 32'(pc_write_o), 32'd1);

        // load to $zero never stalls
        step(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("s2_pc", 32'(pc_write_o), 32'd1);

        // memory access acked on 4th cycle
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        check("s3_memwb", 32'(MEMWB_bubble_o), 32'd1);
        step(0, 0, 0, 0, 0, 1, 1);
        check("s3_advance", 32'(stage_write_o), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);

        // redirect alone, then redirect with load-use on rt
        step(0, 0, 0, 0, 1, 0, 0);
        check("s4_flush", 32'(IFID_flush_o), 32'd1);
        step(1, 5'd3, 5'd1, 5'd3, 1, 0, 0);
        check("s4_lu_first", 32'(IFID_flush_o), 32'd0);
        step(1, 5'd3, 5'd1, 5'd3, 1, 0, 0);
        check("s4_flush_next", 32'(IFID_flush_o), 32'd1);

        // ack never arrives: timeout sticks until reset
        step(0, 0, 0, 0, 0, 1, 0);
        repeat (MT + 3) step(0, 0, 0, 0, 0, 1, 0);
        check("s5_timeout", 32'(timeout_o), 32'd1);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        check("s5_cleared", 32'({timeout_o, pc_write_o}), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(1) == 1,
                     RW'($urandom_range(3)),
                     RW'($urandom_range(3)),
                     RW'($urandom_range(3)),
                     $urandom_range(3) == 0,
                     $urandom_range(3) == 0,
                     $urandom_range(9) < 4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
